regs_wb: RTL and testbench
==========================

# regs_wb

Writeback sequencer driving the single write port of the 32×32 `regs` register file. It merges single-cycle ALU results with out-of-order-in-time, in-order-in-sequence load returns into one registered write stream. It tracks outstanding load destinations in a tag FIFO and exports a per-register busy scoreboard so the issue stage can stall on RAW/WAW hazards. It sits between execute/LSU and `regs`.

## Interface
- `DEPTH`, 4: maximum outstanding loads (tag FIFO entries); power of two, 2..16.
- `PLATFORM`, "XILINX": target selector, passed through to the FIFO.

- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `alu_rda` in 5: ALU destination register.
- `alu_rd` in 32: ALU result.
- `alu_rdw` in 1: ALU write request; always accepted.
- `ld_issue` in 1: load issued; takes effect only when `ld_ready`=1.
- `ld_rda` in 5: load destination register, sampled with `ld_issue`.
- `ld_ready` out 1: tag FIFO not full.
- `ld_valid` in 1: load data returning, in issue order.
- `ld_data` in 32: load data.
- `ld_ack` out 1: load data accepted this cycle; equals `!skid_full`, combinational.
- `rda` out 5: to `regs.rda`, registered.
- `rd` out 32: to `regs.rd`, registered.
- `rdw` out 1: to `regs.rdw`, registered.
- `busy` out 32: bit r set while a load write to xr is not yet committed; bit 0 is always 0.
- `err` out 1: sticky protocol error.

## Operation
- Tag FIFO: push `ld_rda` on `ld_issue && ld_ready`. Pop on `ld_valid && ld_ack`; the popped tag is the destination of `ld_data`.
- Skid register holds {tag, data, full}: one load result that lost arbitration.
- Write arbitration each cycle, in priority order:
  1. ALU, if `alu_rdw && alu_rda!=0`.
  2. Skid, if full.
  3. Incoming accepted load.
- A load that loses arbitration goes to the skid. The skid fills only when it is empty (`ld_ack`=1).
- Writes to x0 are never emitted (`rdw` stays 0). A load to x0 still pushes and pops a tag, but its data is dropped.
- busy[r] = OR of:
  - any valid FIFO tag equal to r;
  - skid full with tag r;
  - output stage holding a load write to r with `rdw`=1.
- Consumer rule: the issue stage must not issue an ALU op whose destination is busy. This block does not reorder writes to the same register.
- `ld_valid` while the FIFO is empty: data ignored, no pop, `err`←1. `err` clears only on `rst`.

## Timing
- Reset values:
  - `rda`=0, `rd`=0, `rdw`=0, `busy`=0, `err`=0.
  - `ld_ready`=1, `ld_ack`=1.
  - FIFO and skid empty.
- Latency is 1 cycle from a winning request to `rdw`=1. `regs` commits at the following edge.
- A skid entry drains on the first cycle without a valid ALU write. It adds 1 cycle per ALU collision.
- FIFO full: `ld_ready`=0. A same-cycle pop does not re-enable the push; the full flag is registered.
- Push and pop in the same cycle with the FIFO non-full and non-empty: count is unchanged, and the pointers wrap mod DEPTH.
- Push onto an empty FIFO with a same-cycle `ld_valid`: this is `err` (no bypass).
- Reset mid-operation discards all tags and the skid. The LSU must be reset in the same cycle.

## Structure
- Shared header `riscv_pkg.vh`: `XLEN`=32, `REG_AW`=5, `REG_N`=32. These are shared with `regs` and the decoder.
- Sub-module `wb_tag_fifo`: a DEPTH×5 synchronous FIFO with registered full/empty. Its tag vector is exposed for the busy OR-reduction.
- Arbitration, skid, output registers and busy logic stay in `regs_wb`.

## Test plan
- Reset, then `alu_rdw`=1, `alu_rda`=5, `alu_rd`=0xDEADBEEF → next cycle `rdw`=1, `rda`=5, `rd`=0xDEADBEEF. `busy`=0 throughout.
- Issue a load to x7, return 0x12345678 three cycles later → `busy[7]`=1 from the cycle after issue through the `rdw` cycle, then 0. The write x7=0x12345678 appears 1 cycle after return.
- Load return to x3 in the same cycle as an ALU write to x9 → `rdw` writes x9 first, then x3. `ld_ack`=0 for one cycle; a second `ld_valid` is held off and lands on the third cycle.
- Issue 4 loads with DEPTH=4 → `ld_ready`=0. Return one → `ld_ready`=1 the next cycle. Return the rest → writes are in issue order.
- Load to x0 returning 0xFFFFFFFF → no `rdw`, FIFO empties, `busy`=0.
- `ld_valid` with an empty FIFO → `err`=1 and it holds through further traffic. `rst` → `err`=0 and all outputs return to reset values.

Source files
------------

// File: rtl/regs_wb_pkg.sv
// Shared types and sizes for the writeback sequencer: register-file geometry,
// skid entry layout and the write-source selector.
package regs_wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int REG_N  = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xword_t;

    typedef struct packed {
        reg_addr_t tag;
        xword_t    data;
        logic      full;
    } skid_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_SKID,
        SRC_LOAD
    } wb_src_e;

    function automatic logic [REG_N-1:0] reg_onehot(input reg_addr_t a);
        logic [REG_N-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_tag_fifo.sv
// DEPTH x 5-bit tag FIFO holding outstanding load destinations, with registered
// full/empty flags and a per-entry valid mask exported for the busy scoreboard.
module wb_tag_fifo
    import regs_wb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter     PLATFORM = "XILINX"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [REG_AW-1:0]       push_tag,
    input  logic                    pop,
    output logic [REG_AW-1:0]       pop_tag,
    output logic                    full,
    output logic                    empty,
    output logic [DEPTH*REG_AW-1:0] tags,
    output logic [DEPTH-1:0]        valid
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_next;
    logic          do_push, do_pop;
    reg_addr_t     mem [DEPTH];

    // Push is gated by the registered full flag, so a same-cycle pop never frees a slot early.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (do_pop && !do_push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            valid  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                valid[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                valid[rd_ptr] <= 1'b0;
            end
            count <= count_next;
            full  <= (count_next == (PW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    generate
        if (PLATFORM == "XILINX") begin : g_lutram
            // NOTE: storage is left unreset so it maps to distributed RAM; the valid mask alone marks live entries.
            always_ff @(posedge clk) begin
                if (do_push)
                    mem[wr_ptr] <= push_tag;
            end
        end else begin : g_flops
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++)
                        mem[i] <= '0;
                end else if (do_push) begin
                    mem[wr_ptr] <= push_tag;
                end
            end
        end
    endgenerate

    assign pop_tag = mem[rd_ptr];

    always_comb begin
        tags = '0;
        for (int i = 0; i < DEPTH; i++)
            tags[i*REG_AW +: REG_AW] = mem[i];
    end

endmodule

// File: rtl/regs_wb.sv
// Writeback sequencer: merges ALU results and in-order load returns into the
// single registered write port of the register file and exports a busy scoreboard.
module regs_wb
    import regs_wb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter     PLATFORM = "XILINX"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] alu_rda,
    input  logic [XLEN-1:0]   alu_rd,
    input  logic              alu_rdw,
    input  logic              ld_issue,
    input  logic [REG_AW-1:0] ld_rda,
    output logic              ld_ready,
    input  logic              ld_valid,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ack,
    output logic [REG_AW-1:0] rda,
    output logic [XLEN-1:0]   rd,
    output logic              rdw,
    output logic [REG_N-1:0]  busy,
    output logic              err
);

    logic                    fifo_full, fifo_empty;
    logic [REG_AW-1:0]       ld_tag;
    logic [DEPTH*REG_AW-1:0] fifo_tags;
    logic [DEPTH-1:0]        fifo_valid;

    skid_t     skid;
    wb_src_e   src;
    reg_addr_t win_rda;
    xword_t    win_rd;
    logic      out_load;
    logic      alu_win, ld_acc, ld_live;

    assign ld_ready = !fifo_full;
    assign ld_ack   = !skid.full;
    assign ld_acc   = ld_valid && ld_ack && !fifo_empty;
    assign ld_live  = ld_acc && (ld_tag != '0);
    assign alu_win  = alu_rdw && (alu_rda != '0);

    wb_tag_fifo #(
        .DEPTH    (DEPTH),
        .PLATFORM (PLATFORM)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ld_issue),
        .push_tag (ld_rda),
        .pop      (ld_acc),
        .pop_tag  (ld_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .tags     (fifo_tags),
        .valid    (fifo_valid)
    );

    // ld_acc implies the skid is empty, so at most one of skid/load competes with the ALU.
    always_comb begin
        src     = SRC_NONE;
        win_rda = '0;
        win_rd  = '0;
        if (alu_win) begin
            src     = SRC_ALU;
            win_rda = alu_rda;
            win_rd  = alu_rd;
        end else if (skid.full) begin
            src     = SRC_SKID;
            win_rda = skid.tag;
            win_rd  = skid.data;
        end else if (ld_live) begin
            src     = SRC_LOAD;
            win_rda = ld_tag;
            win_rd  = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid     <= '0;
            rda      <= '0;
            rd       <= '0;
            rdw      <= 1'b0;
            out_load <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (src == SRC_SKID)
                skid.full <= 1'b0;
            else if (ld_live && alu_win)
                skid <= '{tag: ld_tag, data: ld_data, full: 1'b1};

            rdw      <= (src != SRC_NONE);
            out_load <= (src == SRC_SKID) || (src == SRC_LOAD);
            if (src != SRC_NONE) begin
                rda <= win_rda;
                rd  <= win_rd;
            end

            if (ld_valid && fifo_empty)
                err <= 1'b1;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++)
            if (fifo_valid[i])
                busy |= reg_onehot(fifo_tags[i*REG_AW +: REG_AW]);
        if (skid.full)
            busy |= reg_onehot(skid.tag);
        if (rdw && out_load)
            busy |= reg_onehot(rda);
        busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_regs_wb.sv
// Directed self-checking bench for regs_wb: ALU writes, load returns, collisions,
// FIFO full/wrap, x0 loads, error stickiness and reset.
module tb_regs_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  alu_rda;
    logic [31:0] alu_rd;
    logic        alu_rdw;
    logic        ld_issue;
    logic [4:0]  ld_rda;
    logic        ld_ready;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ack;
    logic [4:0]  rda;
    logic [31:0] rd;
    logic        rdw;
    logic [31:0] busy;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    regs_wb #(.DEPTH(4), .PLATFORM("XILINX")) dut (
        .clk      (clk),
        .rst      (rst),
        .alu_rda  (alu_rda),
        .alu_rd   (alu_rd),
        .alu_rdw  (alu_rdw),
        .ld_issue (ld_issue),
        .ld_rda   (ld_rda),
        .ld_ready (ld_ready),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ack   (ld_ack),
        .rda      (rda),
        .rd       (rd),
        .rdw      (rdw),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".rdw"}, 32'(rdw), 32'd0);
        check({tag, ".rda"}, 32'(rda), 32'd0);
        check({tag, ".rd"}, rd, 32'd0);
        check({tag, ".busy"}, busy, 32'd0);
        check({tag, ".err"}, 32'(err), 32'd0);
        check({tag, ".ld_ready"}, 32'(ld_ready), 32'd1);
        check({tag, ".ld_ack"}, 32'(ld_ack), 32'd1);
    endtask

    task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
        check({tag, ".rdw"}, 32'(rdw), 32'd1);
        check({tag, ".rda"}, 32'(rda), 32'(a));
        check({tag, ".rd"}, rd, d);
    endtask

    initial begin
        rst = 1'b1; alu_rda = '0; alu_rd = '0; alu_rdw = 1'b0;
        ld_issue = 1'b0; ld_rda = '0; ld_valid = 1'b0; ld_data = '0;
        tick(); tick();
        rst = 1'b0;
        check_reset_state("reset");

        // ALU write x5
        alu_rdw = 1'b1; alu_rda = 5'd5; alu_rd = 32'hDEADBEEF;
        check("alu.busy_pre", busy, 32'd0);
        tick();
        alu_rdw = 1'b0;
        check_write("alu", 5'd5, 32'hDEADBEEF);
        check("alu.busy", busy, 32'd0);
        tick();
        check("alu.idle_rdw", 32'(rdw), 32'd0);

        // Load to x7, returns three cycles after issue
        ld_issue = 1'b1; ld_rda = 5'd7;
        tick();
        ld_issue = 1'b0;
        check("ld7.busy1", busy, 32'h0000_0080);
        tick();
        check("ld7.busy2", busy, 32'h0000_0080);
        tick();
        ld_valid = 1'b1; ld_data = 32'h12345678;
        check("ld7.ack", 32'(ld_ack), 32'd1);
        check("ld7.busy3", busy, 32'h0000_0080);
        tick();
        ld_valid = 1'b0;
        check_write("ld7", 5'd7, 32'h12345678);
        check("ld7.busy_wr", busy, 32'h0000_0080);
        tick();
        check("ld7.rdw_after", 32'(rdw), 32'd0);
        check("ld7.busy_after", busy, 32'd0);

        // Collision: load x3 returns alongside ALU x9; second load x4 held off
        ld_issue = 1'b1; ld_rda = 5'd3;
        tick();
        ld_rda = 5'd4;
        tick();
        ld_issue = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h0000_0033;
        alu_rdw = 1'b1; alu_rda = 5'd9; alu_rd = 32'h0000_0099;
        tick();
        alu_rdw = 1'b0;
        ld_data = 32'h0000_0044;
        check_write("col.alu", 5'd9, 32'h0000_0099);
        check("col.ack0", 32'(ld_ack), 32'd0);
        check("col.busy_skid", busy, 32'h0000_0018);
        tick();
        check_write("col.skid", 5'd3, 32'h0000_0033);
        check("col.ack1", 32'(ld_ack), 32'd1);
        check("col.busy_drain", busy, 32'h0000_0018);
        tick();
        ld_valid = 1'b0;
        check_write("col.ld4", 5'd4, 32'h0000_0044);
        tick();
        check("col.rdw_after", 32'(rdw), 32'd0);
        check("col.busy_after", busy, 32'd0);

        // Fill the FIFO (pointers wrap), blocked push while full with same-cycle pop
        for (int i = 0; i < 4; i++) begin
            ld_issue = 1'b1; ld_rda = 5'(10 + i);
            check($sformatf("full.ready%0d", i), 32'(ld_ready), 32'd1);
            tick();
        end
        ld_issue = 1'b0;
        check("full.ready", 32'(ld_ready), 32'd0);
        check("full.busy", busy, 32'h0000_3C00);
        ld_issue = 1'b1; ld_rda = 5'd20;
        ld_valid = 1'b1; ld_data = 32'h0000_00A0;
        tick();
        ld_issue = 1'b0;
        check_write("full.ret10", 5'd10, 32'h0000_00A0);
        check("full.ready_again", 32'(ld_ready), 32'd1);
        check("full.busy_no20", busy, 32'h0000_3C00);
        for (int i = 1; i < 4; i++) begin
            ld_data = 32'hA0 + 32'(i);
            tick();
            check_write($sformatf("full.ret%0d", 10 + i), 5'(10 + i), 32'hA0 + 32'(i));
        end
        ld_valid = 1'b0;
        tick();
        check("full.busy_after", busy, 32'd0);
        check("full.err", 32'(err), 32'd0);

        // Load to x0: tag flows, data dropped
        ld_issue = 1'b1; ld_rda = 5'd0;
        tick();
        ld_issue = 1'b0;
        check("x0.busy_issue", busy, 32'd0);
        ld_valid = 1'b1; ld_data = 32'hFFFFFFFF;
        tick();
        ld_valid = 1'b0;
        check("x0.rdw", 32'(rdw), 32'd0);
        check("x0.busy", busy, 32'd0);
        check("x0.err", 32'(err), 32'd0);
        alu_rdw = 1'b1; alu_rda = 5'd0; alu_rd = 32'h1111_1111;
        tick();
        alu_rdw = 1'b0;
        check("x0.alu_rdw", 32'(rdw), 32'd0);

        // ld_valid with empty FIFO: sticky err
        ld_valid = 1'b1; ld_data = 32'h5555_5555;
        tick();
        ld_valid = 1'b0;
        check("err.set", 32'(err), 32'd1);
        check("err.no_write", 32'(rdw), 32'd0);
        alu_rdw = 1'b1; alu_rda = 5'd2; alu_rd = 32'h0000_0002;
        tick();
        alu_rdw = 1'b0;
        check("err.hold", 32'(err), 32'd1);
        check_write("err.alu", 5'd2, 32'h0000_0002);
        ld_issue = 1'b1; ld_rda = 5'd5;
        tick();
        ld_issue = 1'b0;
        check("err.busy5", busy, 32'h0000_0020);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst_mid");

        // Push onto empty FIFO with same-cycle ld_valid: no bypass, err
        ld_issue = 1'b1; ld_rda = 5'd6;
        ld_valid = 1'b1; ld_data = 32'h6666_6666;
        tick();
        ld_issue = 1'b0; ld_valid = 1'b0;
        check("nobyp.err", 32'(err), 32'd1);
        check("nobyp.rdw", 32'(rdw), 32'd0);
        check("nobyp.busy", busy, 32'h0000_0040);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
